// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the multiplexed seven-segment display block:
//   SEG_W       - number of segment lines (A..G)
//   SEG_OFF     - all segments dark (active-low)
//   HEX_LUT     - nibble to active-low A..G pattern, bit6 = A ... bit0 = G
//   state_t     - scanner state encoding
//   clog2_safe  - counter width helper that never returns 0
// -----------------------------------------------------------------------------
package seg_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

  // Active-low glyphs for 0..F, bit6 = segment A, bit0 = segment G.
  localparam logic [SEG_W-1:0] HEX_LUT [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06,   // 0 1 2 3
    7'h4C, 7'h24, 7'h20, 7'h0F,   // 4 5 6 7
    7'h00, 7'h04, 7'h08, 7'h60,   // 8 9 A b
    7'h31, 7'h42, 7'h30, 7'h38    // C d E F
  };

  typedef enum logic {
    ST_OFF,
    ST_SCAN
  } state_t;

  // Width needed to count 0..n-1; at least 1 so a 1-entry counter still has a bit.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// -----------------------------------------------------------------------------
// seg_hex_decode
// Combinational hex nibble to active-low seven-segment pattern.
// Ports:
//   nibble  in  4      value 0..F
//   seg     out SEG_W  active-low segments, bit6 = A ... bit0 = G
// -----------------------------------------------------------------------------
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  assign seg = HEX_LUT[nibble];

endmodule

// File: rtl/seg_scan_display.sv
// -----------------------------------------------------------------------------
// seg_scan_display
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits with
// per-digit blanking, optional hex decoding, PWM brightness, a one-cycle anode
// dead-time at the start of every digit slot and frame-synchronous updates.
//
// Build option: define SEG_PWM_EN to enable PWM brightness. Without it the
// brightness input is ignored and each digit is lit for its whole slot except
// the dead-time cycle; slot length and frame rate do not change.
//
// Ports:
//   app_clk      in   1               application clock
//   app_rst_n    in   1               synchronous active-low reset
//   enable       in   1               1 = scan, 0 = everything dark
//   load         in   1               capture data inputs into staging
//   hex_mode     in   1               1 = show decoded hex_in, 0 = raw_seg_in
//   raw_seg_in   in   NUM_DIGITS*7    raw active-low segments, digit 0 in LSBs
//   hex_in       in   NUM_DIGITS*4    nibble per digit
//   dots_in      in   NUM_DIGITS      active-low dot per digit
//   blank_in     in   NUM_DIGITS      1 = digit dark
//   brightness   in   BRIGHT_W        PWM duty, sampled live
//   AN_out       out  NUM_DIGITS      active-low anodes
//   A_TO_G_out   out  7               active-low segments
//   DOTS_out     out  1               active-low dot
//   frame_done   out  1               pulse at the end of the last digit slot
// -----------------------------------------------------------------------------
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_HZ     = 50000000,
  parameter int REFRESH_HZ = 1000,
  parameter int BRIGHT_W   = 4
) (
  input  logic                        app_clk,
  input  logic                        app_rst_n,
  input  logic                        enable,
  input  logic                        load,
  input  logic                        hex_mode,
  input  logic [NUM_DIGITS*SEG_W-1:0] raw_seg_in,
  input  logic [NUM_DIGITS*4-1:0]     hex_in,
  input  logic [NUM_DIGITS-1:0]       dots_in,
  input  logic [NUM_DIGITS-1:0]       blank_in,
  input  logic [BRIGHT_W-1:0]         brightness,
  output logic [NUM_DIGITS-1:0]       AN_out,
  output logic [SEG_W-1:0]            A_TO_G_out,
  output logic                        DOTS_out,
  output logic                        frame_done
);

  localparam int STEPS = 2 ** BRIGHT_W;
  localparam int PRE   = CLK_HZ / (REFRESH_HZ * NUM_DIGITS * STEPS);
  localparam int PRE_W = clog2_safe(PRE);
  localparam int DIG_W = clog2_safe(NUM_DIGITS);

  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRE - 1);
  localparam logic [DIG_W-1:0]    DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
  localparam logic [BRIGHT_W-1:0] STEP_LAST = '1;

  if (NUM_DIGITS < 1) begin : g_bad_digits
    $error("seg_scan_display: NUM_DIGITS must be >= 1");
  end
  if (PRE < 2) begin : g_bad_pre
    $error("seg_scan_display: prescaler %0d < 2, clock too slow for refresh rate", PRE);
  end

  // ---------------------------------------------------------------------------
  // Scan state and counters
  // ---------------------------------------------------------------------------
  state_t              state;
  logic [PRE_W-1:0]    presc;
  logic [BRIGHT_W-1:0] pwm_step;
  logic [DIG_W-1:0]    digit_idx;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every always_ff sees the pre-edge value of every register it reads.
  always_ff @(posedge app_clk) begin
    if (!app_rst_n) begin
      state     <= ST_OFF;
      presc     <= '0;
      pwm_step  <= '0;
      digit_idx <= '0;
    end else if (!enable) begin
      state     <= ST_OFF;
      presc     <= '0;
      pwm_step  <= '0;
      digit_idx <= '0;
    end else if (state == ST_OFF) begin
      // Counters are already parked at 0, so the first SCAN cycle is the
      // dead-time cycle of digit 0.
      state <= ST_SCAN;
    end else if (presc == PRE_LAST) begin
      presc <= '0;
      if (pwm_step == STEP_LAST) begin
        pwm_step  <= '0;
        digit_idx <= (digit_idx == DIG_LAST) ? '0 : digit_idx + DIG_W'(1);
      end else begin
        pwm_step <= pwm_step + BRIGHT_W'(1);
      end
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Staging and display registers
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0][SEG_W-1:0] stage_raw,   disp_raw;
  logic [NUM_DIGITS-1:0][3:0]       stage_hex,   disp_hex;
  logic [NUM_DIGITS-1:0]            stage_dots,  disp_dots;
  logic [NUM_DIGITS-1:0]            stage_blank, disp_blank;
  logic                             stage_hex_mode, disp_hex_mode;

  // NOTE: these small register banks are reset on purpose; they drive visible
  // pins, so they must come up blank instead of showing power-up garbage.
  always_ff @(posedge app_clk) begin
    if (!app_rst_n) begin
      stage_raw      <= {NUM_DIGITS{SEG_OFF}};
      stage_hex      <= '0;
      stage_dots     <= '1;
      stage_blank    <= '1;
      stage_hex_mode <= 1'b0;
      disp_raw       <= {NUM_DIGITS{SEG_OFF}};
      disp_hex       <= '0;
      disp_dots      <= '1;
      disp_blank     <= '1;
      disp_hex_mode  <= 1'b0;
    end else begin
      if (load) begin
        stage_raw      <= raw_seg_in;
        stage_hex      <= hex_in;
        stage_dots     <= dots_in;
        stage_blank    <= blank_in;
        stage_hex_mode <= hex_mode;
      end
      // frame_done is high during the dead-time cycle of digit 0, so the swap
      // lands while every anode is off and a frame never mixes old and new.
      // A load on that same cycle lands in staging only and shows next frame.
      if (state == ST_OFF || frame_done) begin
        disp_raw      <= stage_raw;
        disp_hex      <= stage_hex;
        disp_dots     <= stage_dots;
        disp_blank    <= stage_blank;
        disp_hex_mode <= stage_hex_mode;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Current-digit segment selection
  // ---------------------------------------------------------------------------
  logic [SEG_W-1:0] cur_hex_seg;
  logic [SEG_W-1:0] cur_seg;
  logic             dead_time;
  logic             duty_on;
  logic             lit;
  logic             frame_end;

  seg_hex_decode u_hex_decode (
    .nibble (disp_hex[digit_idx]),
    .seg    (cur_hex_seg)
  );

  assign cur_seg   = disp_hex_mode ? cur_hex_seg : disp_raw[digit_idx];
  assign dead_time = (presc == '0) && (pwm_step == '0);

`ifdef SEG_PWM_EN
  assign duty_on = (pwm_step < brightness);
`else
  assign duty_on = 1'b1;
  logic unused_brightness;
  assign unused_brightness = ^brightness;
`endif

  // enable is used directly so a falling enable darkens the outputs on the
  // very next edge, while the state register catches up on the same edge.
  assign lit = (state == ST_SCAN) && enable && !disp_blank[digit_idx] &&
               duty_on && !dead_time;

  assign frame_end = (state == ST_SCAN) && enable && (presc == PRE_LAST) &&
                     (pwm_step == STEP_LAST) && (digit_idx == DIG_LAST);

  // ---------------------------------------------------------------------------
  // Registered pin drivers: anodes and segments switch on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge app_clk) begin
    if (!app_rst_n) begin
      AN_out     <= '1;
      A_TO_G_out <= SEG_OFF;
      DOTS_out   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      AN_out     <= ~(NUM_DIGITS'(lit) << digit_idx);
      A_TO_G_out <= lit ? cur_seg : SEG_OFF;
      DOTS_out   <= lit ? disp_dots[digit_idx] : 1'b1;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_display
// Directed bench for seg_scan_display with CLK_HZ=1600, REFRESH_HZ=25,
// NUM_DIGITS=4, BRIGHT_W=2: PWM step = 4 cycles, slot = 16, frame = 64.
// Expected lit-cycle counts follow SEG_PWM_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_seg_scan_display;

`ifdef SEG_PWM_EN
  localparam int ON3 = 11;  // steps 0..2 lit minus the dead-time cycle
  localparam int ON1 = 3;   // step 0 lit minus the dead-time cycle
  localparam int ON0 = 0;
  localparam logic [27:0] SEG_A_B0 = {4{7'h7F}};
  localparam logic [3:0]  DOT_A_B0 = 4'hF;
`else
  localparam int ON3 = 15;
  localparam int ON1 = 15;
  localparam int ON0 = 15;
  localparam logic [27:0] SEG_A_B0 = {7'h4C, 7'h06, 7'h12, 7'h4F};
  localparam logic [3:0]  DOT_A_B0 = 4'b1010;
`endif

  localparam logic [27:0] SEG_A      = {7'h4C, 7'h06, 7'h12, 7'h4F};  // hex 4321
  localparam logic [27:0] SEG_A_BLK2 = {7'h4C, 7'h7F, 7'h12, 7'h4F};
  localparam logic [27:0] RAW_B      = {7'h12, 7'h34, 7'h56, 7'h78};
  localparam logic [27:0] RAW_C      = {7'h2A, 7'h55, 7'h0F, 7'h70};
  localparam logic [27:0] SEG_F      = {7'h38, 7'h30, 7'h42, 7'h31};  // hex FEDC

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic        hex_mode;
  logic [27:0] raw_seg_in;
  logic [15:0] hex_in;
  logic [3:0]  dots_in;
  logic [3:0]  blank_in;
  logic [1:0]  brightness;
  logic [3:0]  AN_out;
  logic [6:0]  A_TO_G_out;
  logic        DOTS_out;
  logic        frame_done;

  always #5 clk = ~clk;

  seg_scan_display #(
    .NUM_DIGITS (4),
    .CLK_HZ     (1600),
    .REFRESH_HZ (25),
    .BRIGHT_W   (2)
  ) dut (
    .app_clk    (clk),
    .app_rst_n  (rst_n),
    .enable     (enable),
    .load       (load),
    .hex_mode   (hex_mode),
    .raw_seg_in (raw_seg_in),
    .hex_in     (hex_in),
    .dots_in    (dots_in),
    .blank_in   (blank_in),
    .brightness (brightness),
    .AN_out     (AN_out),
    .A_TO_G_out (A_TO_G_out),
    .DOTS_out   (DOTS_out),
    .frame_done (frame_done)
  );

  int          total  = 0;
  int          passed = 0;
  int          low_cnt [4];
  logic [27:0] seen_seg;
  logic [3:0]  seen_dot;
  int          bad;
  int          fd_cnt;
  int          fd_pos;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic is_dark();
    return (AN_out === 4'hF) && (A_TO_G_out === 7'h7F) &&
           (DOTS_out === 1'b1) && (frame_done === 1'b0);
  endfunction

  function automatic logic [31:0] cnts(input int c0, input int c1, input int c2, input int c3);
    return {c3[7:0], c2[7:0], c1[7:0], c0[7:0]};
  endfunction

  // Bounded wait for the next frame_done sample.
  task automatic wait_fd(output int n, output logic any_lit);
    n = -1;
    any_lit = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (AN_out !== 4'hF) any_lit = 1'b1;
      if (frame_done === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  // Observe one full frame starting right after a frame_done sample. Sample i
  // belongs to the slot of digit i/16. load pulses for one edge after sample
  // load_at (63 makes it coincide with the closing frame_done cycle).
  task automatic measure_frame(input int load_at);
    int         d;
    logic [3:0] exp_an;
    for (int k = 0; k < 4; k++) low_cnt[k] = 0;
    seen_seg = {4{7'h7F}};
    seen_dot = 4'hF;
    bad      = 0;
    fd_cnt   = 0;
    fd_pos   = -1;
    for (int i = 0; i < 64; i++) begin
      tick();
      d      = i / 16;
      exp_an = ~(4'b0001 << d);
      if (AN_out !== 4'hF) begin
        if (AN_out !== exp_an) begin
          bad++;
        end else begin
          if (low_cnt[d] > 0 && seen_seg[7*d +: 7] !== A_TO_G_out) bad++;
          low_cnt[d]++;
          seen_seg[7*d +: 7] = A_TO_G_out;
          seen_dot[d]        = DOTS_out;
        end
      end else if (A_TO_G_out !== 7'h7F || DOTS_out !== 1'b1) begin
        bad++;
      end
      if (frame_done === 1'b1) begin
        fd_cnt++;
        fd_pos = i;
      end
      load = (i == load_at);
    end
  endtask

  task automatic check_frame(input string tag, input logic [31:0] exp_cnt,
                             input logic [27:0] exp_seg, input logic [3:0] exp_dot);
    check({tag, "_lit_cycles"}, cnts(low_cnt[0], low_cnt[1], low_cnt[2], low_cnt[3]), exp_cnt);
    check({tag, "_segments"}, 32'(seen_seg), 32'(exp_seg));
    check({tag, "_dots"}, 32'(seen_dot), 32'(exp_dot));
    check({tag, "_glitches"}, bad, 0);
    check({tag, "_frame_done_pos"}, fd_pos, 63);
    check({tag, "_frame_done_cnt"}, fd_cnt, 1);
  endtask

  initial begin
    int   n;
    int   dark_bad;
    logic any_lit;

    rst_n      = 1'b0;
    enable     = 1'b1;
    load       = 1'b0;
    hex_mode   = 1'b1;
    raw_seg_in = '0;
    hex_in     = 16'h4321;
    dots_in    = 4'b1010;
    blank_in   = 4'b0000;
    brightness = 2'd3;

    // Dark throughout reset, even with enable high.
    dark_bad = 0;
    repeat (5) begin
      tick();
      if (!is_dark()) dark_bad++;
    end
    check("reset_dark", dark_bad, 0);

    // Release with a load: display stays blank for the first frame.
    rst_n = 1'b1;
    load  = 1'b1;
    tick();
    check("release_c0_dark", 32'(is_dark()), 1);
    load = 1'b0;
    wait_fd(n, any_lit);
    check("first_frame_done_cycle", n, 64);
    check("first_frame_blank", 32'(any_lit), 0);

    measure_frame(-1);
    check_frame("hex4321_b3", cnts(ON3, ON3, ON3, ON3), SEG_A, 4'b1010);

    brightness = 2'd1;
    measure_frame(-1);
    check_frame("hex4321_b1", cnts(ON1, ON1, ON1, ON1), SEG_A, 4'b1010);

    brightness = 2'd0;
    measure_frame(-1);
    check_frame("hex4321_b0", cnts(ON0, ON0, ON0, ON0), SEG_A_B0, DOT_A_B0);

    // Blank digit 2; loaded mid-frame so it takes effect next frame.
    brightness = 2'd3;
    blank_in   = 4'b0100;
    measure_frame(10);
    check_frame("blank_load_frame", cnts(ON3, ON3, ON3, ON3), SEG_A, 4'b1010);
    measure_frame(-1);
    check_frame("blank_digit2", cnts(ON3, ON3, 0, ON3), SEG_A_BLK2, 4'b1110);

    // Mid-frame load of raw data: old data until frame_done.
    hex_mode   = 1'b0;
    raw_seg_in = RAW_B;
    blank_in   = 4'b0000;
    measure_frame(20);
    check_frame("midload_old", cnts(ON3, ON3, 0, ON3), SEG_A_BLK2, 4'b1110);
    measure_frame(-1);
    check_frame("midload_new", cnts(ON3, ON3, ON3, ON3), RAW_B, 4'b1010);

    // Load coincident with frame_done: delayed a full frame.
    raw_seg_in = RAW_C;
    measure_frame(63);
    check_frame("fdload_cur", cnts(ON3, ON3, ON3, ON3), RAW_B, 4'b1010);
    measure_frame(-1);
    check_frame("fdload_held", cnts(ON3, ON3, ON3, ON3), RAW_B, 4'b1010);
    measure_frame(-1);
    check_frame("fdload_new", cnts(ON3, ON3, ON3, ON3), RAW_C, 4'b1010);

    // Drop enable mid-slot of digit 0.
    repeat (5) tick();
    check("pre_drop_anode", 32'(AN_out), 32'(4'b1110));
    enable = 1'b0;
    tick();
    check("drop_dark_next_cycle", 32'(is_dark()), 1);

    // Load while off: copied straight through to the display.
    hex_mode = 1'b1;
    hex_in   = 16'hFEDC;
    load     = 1'b1;
    dark_bad = 0;
    tick();
    if (!is_dark()) dark_bad++;
    load = 1'b0;
    repeat (3) begin
      tick();
      if (!is_dark()) dark_bad++;
    end
    check("off_dark", dark_bad, 0);

    // Raise enable: restart at digit 0 with a dead-time cycle.
    enable = 1'b1;
    tick();
    check("rise_r0_dark", 32'(is_dark()), 1);
    tick();
    check("rise_r1_deadtime", 32'(is_dark()), 1);
    tick();
    check("rise_r2_anode", 32'(AN_out), 32'(4'b1110));
    check("rise_r2_segments", 32'(A_TO_G_out), 32'(7'h31));
    wait_fd(n, any_lit);
    check("rise_frame_done_cycle", n, 62);
    measure_frame(-1);
    check_frame("hexFEDC", cnts(ON3, ON3, ON3, ON3), SEG_F, 4'b1010);

    // Reset mid-slot: dark on the next edge, then a blank first frame.
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    check("rst_mid_dark", 32'(is_dark()), 1);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_rel_c0_dark", 32'(is_dark()), 1);
    wait_fd(n, any_lit);
    check("rst_frame_done_cycle", n, 64);
    check("rst_display_blank", 32'(any_lit), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
